// File: rtl/sprite_compositor_pkg.sv
// sprite_compositor_pkg: screen constants, default colours and packed coordinate slicing
package sprite_compositor_pkg;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int MAX_SPRITES = 32;
    localparam logic [11:0] COLOR_WHITE = 12'hfff;
    localparam logic [11:0] COLOR_BLACK = 12'h000;
    function automatic logic [9:0] coord10(input logic [10*MAX_SPRITES-1:0] v, input int i);
        return v[10*i +: 10];
    endfunction
endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: timing, sprite-state, ROM and colour signals of the compositor
interface sprite_compositor_if #(
    parameter int NUM_SPRITES = 4,
    parameter int ADDR_W = 14
);
    localparam int ID_W = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
    logic                          pix_en;
    logic                          frame_start;
    logic [9:0]                    x;
    logic [8:0]                    y;
    logic                          active;
    logic [NUM_SPRITES*10-1:0]     spr_x;
    logic [NUM_SPRITES*10-1:0]     spr_y;
    logic [NUM_SPRITES-1:0]        spr_en;
    logic [NUM_SPRITES*2-1:0]      spr_frame;
    logic [NUM_SPRITES*ADDR_W-1:0] rom_addr;
    logic [NUM_SPRITES-1:0]        rom_data;
    logic                          bg_data;
    logic [11:0]                   color_out;
    logic [ID_W-1:0]               hit_id;
    logic                          hit_valid;
    logic [NUM_SPRITES-1:0]        collision_mask;
    logic                          collide_pulse;
    modport master (
        output pix_en, frame_start, x, y, active, spr_x, spr_y, spr_en, spr_frame, rom_data, bg_data,
        input  rom_addr, color_out, hit_id, hit_valid, collision_mask, collide_pulse
    );
    modport slave (
        input  pix_en, frame_start, x, y, active, spr_x, spr_y, spr_en, spr_frame, rom_data, bg_data,
        output rom_addr, color_out, hit_id, hit_valid, collision_mask, collide_pulse
    );
endinterface

// File: rtl/sprite_compositor_channel.sv
// sprite_channel: per-sprite shadow state, box test and ROM address generation
module sprite_channel
    import sprite_compositor_pkg::*;
#(
    parameter int SPR_W = 60,
    parameter int SPR_H = 60,
    parameter int NUM_FRAMES = 4,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_en_i,
    input  logic              frame_start_i,
    input  logic [9:0]        x_i,
    input  logic [8:0]        y_i,
    input  logic [9:0]        spr_x_i,
    input  logic [9:0]        spr_y_i,
    input  logic              spr_en_i,
    input  logic [1:0]        spr_frame_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              in_box_o
);
    localparam int FRAME_SZ = SPR_W * SPR_H;
    logic [9:0]        sx_q, sy_q;
    logic              en_q, in_box_q, in_box_d;
    logic [1:0]        fr_q, fr_eff;
    logic [10:0]       dx, dy;
    logic [ADDR_W-1:0] addr_q, addr_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            sx_q <= '0;
            sy_q <= '0;
            en_q <= 1'b0;
            fr_q <= '0;
            addr_q <= '0;
            in_box_q <= 1'b0;
        end else begin
            if (frame_start_i) begin
                sx_q <= spr_x_i;
                sy_q <= spr_y_i;
                en_q <= spr_en_i;
                fr_q <= spr_frame_i;
            end
            if (pix_en_i) begin
                addr_q <= addr_d;
                in_box_q <= in_box_d;
            end
        end
    end
    // 11-bit offsets: a pixel left of or above the box wraps to a value far beyond the box size
    always_comb begin
        dx = {1'b0, x_i} - {1'b0, sx_q};
        dy = {2'b0, y_i} - {1'b0, sy_q};
        in_box_d = en_q & (dx < 11'(SPR_W)) & (dy < 11'(SPR_H));
        fr_eff = int'(fr_q) < NUM_FRAMES ? fr_q : 2'd0;
        addr_d = in_box_d ? ADDR_W'(32'(fr_eff) * FRAME_SZ + 32'(dy) * SPR_W + 32'(dx)) : '0;
    end
    assign rom_addr_o = addr_q;
    assign in_box_o = in_box_q;
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: N-sprite scanline compositor with priority, colour mux and frame collision flags
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPR_W = 60,
    parameter int          SPR_H = 60,
    parameter int          NUM_FRAMES = 4,
    parameter int          ADDR_W = 14,
    parameter logic [11:0] FG_COLOR = 12'h000
) (
    input logic               clk,
    input logic               reset,
    sprite_compositor_if.slave bus
);
    localparam int ID_W = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
    logic [10*MAX_SPRITES-1:0]     sx_ext, sy_ext;
    logic [NUM_SPRITES*ADDR_W-1:0] rom_addr;
    logic [NUM_SPRITES-1:0]        in_box_q, opaque, overlap, acc_q, acc_d, mask_q;
    logic                          active_q, hit_valid_q, pulse_q;
    logic [ID_W-1:0]               hit_id_q, hit_id_d;
    logic [11:0]                   color_q, color_d;
    assign sx_ext = (10*MAX_SPRITES)'(bus.spr_x);
    assign sy_ext = (10*MAX_SPRITES)'(bus.spr_y);
    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
        sprite_channel #(
            .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NUM_FRAMES), .ADDR_W(ADDR_W)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .pix_en_i(bus.pix_en),
            .frame_start_i(bus.frame_start),
            .x_i(bus.x),
            .y_i(bus.y),
            .spr_x_i(coord10(sx_ext, i)),
            .spr_y_i(coord10(sy_ext, i)),
            .spr_en_i(bus.spr_en[i]),
            .spr_frame_i(bus.spr_frame[2*i +: 2]),
            .rom_addr_o(rom_addr[ADDR_W*i +: ADDR_W]),
            .in_box_o(in_box_q[i])
        );
    end
    // A pixel overlapping with frame_start lands in the freshly cleared accumulator
    always_comb begin
        opaque = in_box_q & bus.rom_data;
        overlap = (opaque & (opaque - NUM_SPRITES'(1))) != '0 ? opaque : '0;
        hit_id_d = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--)
            if (opaque[i]) hit_id_d = ID_W'(i);
        color_d = !active_q ? COLOR_BLACK : |opaque ? FG_COLOR : bus.bg_data ? COLOR_BLACK : COLOR_WHITE;
        acc_d = (bus.frame_start ? '0 : acc_q) | (bus.pix_en ? overlap : '0);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            hit_id_q <= '0;
            hit_valid_q <= 1'b0;
            color_q <= '0;
            acc_q <= '0;
            mask_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            if (bus.pix_en) begin
                active_q <= bus.active;
                hit_id_q <= hit_id_d;
                hit_valid_q <= |opaque;
                color_q <= color_d;
            end
            if (bus.frame_start) mask_q <= acc_q;
            acc_q <= acc_d;
            pulse_q <= bus.frame_start & |acc_q;
        end
    end
    assign bus.rom_addr = rom_addr;
    assign bus.color_out = color_q;
    assign bus.hit_id = hit_id_q;
    assign bus.hit_valid = hit_valid_q;
    assign bus.collision_mask = mask_q;
    assign bus.collide_pulse = pulse_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomized checks against a pixel-level reference model
module tb_sprite_compositor;
    import sprite_compositor_pkg::*;
    localparam int N = 4, W = 60, H = 60, NF = 4, AW = 14;
    localparam logic [11:0] FG = 12'h000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    sprite_compositor_if #(.NUM_SPRITES(N), .ADDR_W(AW)) bus ();
    sprite_compositor #(
        .NUM_SPRITES(N), .SPR_W(W), .SPR_H(H), .NUM_FRAMES(NF), .ADDR_W(AW), .FG_COLOR(FG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );
    int n_checks = 0, n_errors = 0;
    bit rom_all = 1'b1;
    int s_x[N], s_y[N], s_fr[N];
    bit s_en[N];
    int sh_x[N], sh_y[N], sh_fr[N];
    bit sh_en[N];
    int cur_x, cur_y;
    bit cur_act, cur_bg;
    bit pa_in[N];
    int pa_addr[N];
    bit pa_act;
    logic [11:0] e_color;
    int e_id;
    bit e_valid, e_pulse;
    logic [N-1:0] acc, e_mask;
    logic [N-1:0] rom_d;

    function automatic bit rom_bit(input int s, input int a);
        return rom_all || ((a * 37 + s * 11) >> 3) % 2 == 1;
    endfunction
    always_comb
        for (int i = 0; i < N; i++)
            rom_d[i] = rom_all || ((int'(bus.rom_addr[AW*i +: AW]) * 37 + i * 11) >> 3) % 2 == 1;
    assign bus.rom_data = rom_d;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_fr[i] = 0; sh_en[i] = 0;
            pa_in[i] = 0; pa_addr[i] = 0;
        end
        pa_act = 0; e_color = '0; e_id = 0; e_valid = 0; e_pulse = 0;
        acc = '0; e_mask = '0;
    endtask

    task automatic model_edge(input bit pe, input bit fs);
        logic [N-1:0] op;
        int dx, dy;
        op = '0;
        if (pe) begin
            for (int i = 0; i < N; i++) op[i] = pa_in[i] && rom_bit(i, pa_addr[i]);
            e_valid = op != '0;
            e_id = 0;
            for (int i = 0; i < N; i++)
                if (op[i]) begin
                    e_id = i;
                    break;
                end
            e_color = !pa_act ? 12'h000 : e_valid ? FG : cur_bg ? 12'h000 : 12'hfff;
            for (int i = 0; i < N; i++) begin
                dx = cur_x - sh_x[i];
                dy = cur_y - sh_y[i];
                pa_in[i] = sh_en[i] && dx >= 0 && dx < W && dy >= 0 && dy < H;
                pa_addr[i] = pa_in[i] ? (sh_fr[i] < NF ? sh_fr[i] : 0) * W * H + dy * W + dx : 0;
            end
            pa_act = cur_act;
        end
        e_pulse = fs && acc != '0;
        if (fs) begin
            e_mask = acc;
            acc = '0;
            for (int i = 0; i < N; i++) begin
                sh_x[i] = s_x[i]; sh_y[i] = s_y[i]; sh_fr[i] = s_fr[i]; sh_en[i] = s_en[i];
            end
        end
        if (pe && $countones(op) >= 2) acc |= op;
    endtask

    task automatic compare_outputs();
        for (int i = 0; i < N; i++)
            check($sformatf("rom_addr%0d", i), 32'(bus.rom_addr[AW*i +: AW]), pa_addr[i]);
        check("color_out", 32'(bus.color_out), 32'(e_color));
        check("hit_valid", 32'(bus.hit_valid), 32'(e_valid));
        if (e_valid) check("hit_id", 32'(bus.hit_id), e_id);
        check("collision_mask", 32'(bus.collision_mask), 32'(e_mask));
        check("collide_pulse", 32'(bus.collide_pulse), 32'(e_pulse));
    endtask

    task automatic tick(input bit pe, input bit fs);
        bus.pix_en = pe;
        bus.frame_start = fs;
        @(posedge clk);
        if (reset) model_reset();
        else model_edge(pe, fs);
        #1;
        bus.pix_en = 1'b0;
        bus.frame_start = 1'b0;
        compare_outputs();
    endtask

    task automatic set_sprite(input int i, input int px, input int py, input bit en, input int f);
        s_x[i] = px; s_y[i] = py; s_en[i] = en; s_fr[i] = f;
        bus.spr_x[10*i +: 10] = 10'(px);
        bus.spr_y[10*i +: 10] = 10'(py);
        bus.spr_en[i] = en;
        bus.spr_frame[2*i +: 2] = 2'(f);
    endtask

    // three idle clocks, then the pixel strobe; returns just after that strobe's edge
    task automatic pixel(input int px, input int py, input bit act, input bit bg, input bit fs);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0);
        cur_x = px; cur_y = py; cur_act = act; cur_bg = bg;
        bus.x = 10'(px);
        bus.y = 9'(py);
        bus.active = act;
        bus.bg_data = bg;
        tick(1'b1, fs);
    endtask

    task automatic fstart();
        tick(1'b0, 1'b1);
    endtask

    task automatic clear_sprites();
        for (int i = 0; i < N; i++) set_sprite(i, 0, 0, 1'b0, 0);
    endtask

    initial begin
        int px, py;
        bus.pix_en = 1'b0; bus.frame_start = 1'b0;
        bus.x = '0; bus.y = '0; bus.active = 1'b0; bus.bg_data = 1'b0;
        cur_x = 0; cur_y = 0; cur_act = 0; cur_bg = 0;
        clear_sprites();
        model_reset();
        reset = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("reset_color", 32'(bus.color_out), 32'h0);
        check("reset_mask", 32'(bus.collision_mask), 32'h0);
        reset = 1'b0;
        fstart();
        // background, blanking and two-strobe latency
        pixel(4, 5, 1'b0, 1'b0, 1'b0);
        pixel(5, 5, 1'b1, 1'b0, 1'b0);
        check("lat_not_early", 32'(bus.color_out), 32'h0);
        pixel(6, 5, 1'b0, 1'b0, 1'b0);
        check("bg_white", 32'(bus.color_out), 32'hfff);
        pixel(7, 5, 1'b1, 1'b0, 1'b0);
        check("blanked", 32'(bus.color_out), 32'h0);
        // priority and collision publish
        set_sprite(0, 100, 200, 1'b1, 0);
        set_sprite(1, 100, 200, 1'b1, 0);
        fstart();
        pixel(110, 210, 1'b1, 1'b0, 1'b0);
        pixel(111, 210, 1'b1, 1'b0, 1'b0);
        check("prio_id", 32'(bus.hit_id), 32'd0);
        check("prio_valid", 32'(bus.hit_valid), 32'd1);
        check("prio_color", 32'(bus.color_out), 32'h000);
        fstart();
        check("prio_mask", 32'(bus.collision_mask), 32'b0011);
        check("prio_pulse", 32'(bus.collide_pulse), 32'd1);
        tick(1'b0, 1'b0);
        check("prio_pulse_end", 32'(bus.collide_pulse), 32'd0);
        // double buffering
        set_sprite(1, 0, 0, 1'b0, 0);
        fstart();
        set_sprite(0, 300, 200, 1'b1, 0);
        pixel(110, 210, 1'b1, 1'b0, 1'b0);
        pixel(310, 210, 1'b1, 1'b0, 1'b0);
        check("dbuf_old_pos", 32'(bus.hit_valid), 32'd1);
        pixel(0, 0, 1'b1, 1'b0, 1'b0);
        check("dbuf_new_pending", 32'(bus.hit_valid), 32'd0);
        fstart();
        pixel(310, 210, 1'b1, 1'b0, 1'b0);
        pixel(110, 210, 1'b1, 1'b0, 1'b0);
        check("dbuf_new_pos", 32'(bus.hit_valid), 32'd1);
        pixel(0, 0, 1'b1, 1'b0, 1'b0);
        check("dbuf_old_gone", 32'(bus.hit_valid), 32'd0);
        // addressing with right-edge clipping
        clear_sprites();
        set_sprite(2, 620, 0, 1'b1, 3);
        fstart();
        pixel(639, 5, 1'b1, 1'b0, 1'b0);
        check("addr_clip", 32'(bus.rom_addr[AW*2 +: AW]), 32'd11119);
        pixel(0, 5, 1'b1, 1'b0, 1'b0);
        check("addr_outside", 32'(bus.rom_addr[AW*2 +: AW]), 32'd0);
        // overlap only on the pixel coincident with frame_start
        clear_sprites();
        set_sprite(0, 100, 200, 1'b1, 0);
        set_sprite(1, 100, 200, 1'b1, 0);
        fstart();
        pixel(500, 400, 1'b1, 1'b0, 1'b0);
        pixel(110, 210, 1'b1, 1'b0, 1'b0);
        pixel(500, 400, 1'b1, 1'b0, 1'b1);
        check("bnd_mask_old", 32'(bus.collision_mask), 32'd0);
        check("bnd_pulse_old", 32'(bus.collide_pulse), 32'd0);
        pixel(500, 400, 1'b1, 1'b0, 1'b0);
        fstart();
        check("bnd_mask_new", 32'(bus.collision_mask), 32'b0011);
        check("bnd_pulse_new", 32'(bus.collide_pulse), 32'd1);
        // reset mid-frame with collisions accumulated
        pixel(110, 210, 1'b1, 1'b0, 1'b0);
        pixel(111, 210, 1'b1, 1'b0, 1'b0);
        pixel(112, 210, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick(1'b0, 1'b0);
        reset = 1'b0;
        check("rst_color", 32'(bus.color_out), 32'h0);
        check("rst_valid", 32'(bus.hit_valid), 32'd0);
        check("rst_id", 32'(bus.hit_id), 32'd0);
        check("rst_mask", 32'(bus.collision_mask), 32'd0);
        check("rst_addr0", 32'(bus.rom_addr[AW*0 +: AW]), 32'd0);
        pixel(110, 210, 1'b1, 1'b0, 1'b0);
        pixel(111, 210, 1'b1, 1'b0, 1'b0);
        check("rst_bg_only", 32'(bus.hit_valid), 32'd0);
        fstart();
        check("rst_pub_mask", 32'(bus.collision_mask), 32'd0);
        check("rst_pub_pulse", 32'(bus.collide_pulse), 32'd0);
        // randomized frames with hashed bitmaps, mid-frame state changes and coincident frame_start
        rom_all = 1'b0;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < N; i++)
                set_sprite(i,
                    $urandom_range(0, 3) == 0 ? $urandom_range(SCREEN_W - 50, SCREEN_W - 1) : $urandom_range(180, 260),
                    $urandom_range(0, 3) == 0 ? $urandom_range(SCREEN_H - 50, SCREEN_H - 1) : $urandom_range(100, 160),
                    $urandom_range(0, 4) != 0, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) fstart();
            else pixel($urandom_range(0, 799), $urandom_range(0, 511), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            for (int p = 0; p < 70; p++) begin
                if ($urandom_range(0, 15) == 0)
                    set_sprite($urandom_range(0, N - 1), $urandom_range(0, 700), $urandom_range(0, 500),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3));
                px = $urandom_range(0, 3) != 0 ? $urandom_range(170, 330) : $urandom_range(0, 799);
                py = $urandom_range(0, 3) != 0 ? $urandom_range(90, 230) : $urandom_range(0, 511);
                pixel(px, py, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        fstart();
        tick(1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
